// File: rtl/cmd_frame_queue.sv
// Assembles {lmotor, rmotor, dur} byte triples from a UART stream and queues them in a
// small first-word-fall-through FIFO for the motor command executor.
module cmd_frame_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TW      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_valid,
  output logic [7:0]                   cmd_lmotor,
  output logic [7:0]                   cmd_rmotor,
  output logic [7:0]                   cmd_dur,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StS0, StS1, StS2} asm_st_e;

  asm_st_e       st_q;
  logic [TW-1:0] tmr_q;
  logic [7:0]    lm_q, rm_q;

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        push, pop, full, wr_en;
  logic [23:0] frame;

  // Byte assembler with inter-byte timeout; a byte on the expiry cycle still wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= StS0;
      tmr_q     <= '0;
      lm_q      <= '0;
      rm_q      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid) begin
        tmr_q <= '0;
        unique case (st_q)
          StS0: begin
            lm_q <= rx_byte;
            st_q <= StS1;
          end
          StS1: begin
            rm_q <= rx_byte;
            st_q <= StS2;
          end
          StS2:    st_q <= StS0;
          default: st_q <= StS0;
        endcase
      end else if (st_q != StS0) begin
        if (tmr_q == TW'(TIMEOUT - 1)) begin
          st_q      <= StS0;
          tmr_q     <= '0;
          frame_err <= 1'b1;
        end else begin
          tmr_q <= tmr_q + TW'(1);
        end
      end
    end
  end

  assign push      = rx_valid && (st_q == StS2);
  assign frame     = {lm_q, rm_q, rx_byte};
  assign cmd_valid = (count_q != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign full      = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot the full-queue push needs.
  assign wr_en     = push && (!full || pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (pop)   rptr_d = rptr_q + AW'(1);
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      overflow <= push && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= frame;
  end

  assign {cmd_lmotor, cmd_rmotor, cmd_dur} = cmd_valid ? mem_q[rptr_q] : 24'h0;
  assign count = count_q;

endmodule

// File: tb/tb_cmd_frame_queue.sv
// Randomised and directed bench for cmd_frame_queue: a time-based frame model feeds a
// scoreboard that a negedge monitor checks against every DUT output.
module tb_cmd_frame_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 256;
  localparam int unsigned TW      = 9;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [7:0]    cmd_lmotor, cmd_rmotor, cmd_dur;
  logic          cmd_valid;
  logic [CW-1:0] count;
  logic          frame_err, overflow;

  always #5 clk = ~clk;

  cmd_frame_queue #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .cmd_lmotor(cmd_lmotor),
    .cmd_rmotor(cmd_rmotor),
    .cmd_dur   (cmd_dur),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: bytes gathered so far, cycles since last byte, queued frames.
  logic [23:0] exp_q[$];
  int          mcount = 0;
  int          idx = 0;
  int          since = 0;
  logic [7:0]  m_l = 8'h00, m_r = 8'h00;
  int          exp_err = 0, exp_ovf = 0;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;
  int          err_seen = 0, ovf_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules for one clock edge using the inputs the bench is driving.
  task automatic model_edge();
    bit pop, push;
    logic [23:0] f;
    if (reset) begin
      idx = 0; mcount = 0; since = 0; exp_err = 0; exp_ovf = 0;
      exp_q.delete();
      return;
    end
    exp_err = 0;
    exp_ovf = 0;
    pop  = (mcount > 0) && cmd_ready;
    push = 1'b0;
    f    = '0;
    if (rx_valid) begin
      since = 0;
      if (idx == 0) begin m_l = rx_byte; idx = 1; end
      else if (idx == 1) begin m_r = rx_byte; idx = 2; end
      else begin f = {m_l, m_r, rx_byte}; push = 1'b1; idx = 0; end
    end else if (idx != 0) begin
      since++;
      if (since == TIMEOUT) begin idx = 0; exp_err = 1; end
    end
    if (pop) mcount--;
    if (push) begin
      if (mcount >= DEPTH) exp_ovf = 1;
      else begin exp_q.push_back(f); mcount++; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1);
    send_byte(b, 1);
    send_byte(c, 1);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 200 && mcount > 0; i++) step();
    cmd_ready = 1'b0;
    step();
    check("drain_count", int'(count), 0);
  endtask

  // Monitor: compares every output each cycle and pops the scoreboard on handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count", int'(count), mcount);
        check("cmd_valid", int'(cmd_valid), (mcount > 0) ? 1 : 0);
        check("frame_err", int'(frame_err), exp_err);
        check("overflow", int'(overflow), exp_ovf);
        if (frame_err) err_seen++;
        if (overflow) ovf_seen++;
        if (cmd_valid) begin
          if (exp_q.size() == 0) begin
            check("head_unexpected", 1, 0);
          end else begin
            check("head", int'({cmd_lmotor, cmd_rmotor, cmd_dur}), int'(exp_q[0]));
            if (cmd_ready) void'(exp_q.pop_front());
          end
        end else begin
          check("idle_data", int'({cmd_lmotor, cmd_rmotor, cmd_dur}), 0);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, o0, g;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;

    // Widely spaced bytes form one frame, visible right after the third byte's edge.
    send_byte(8'h95, 200);
    send_byte(8'hB6, 200);
    send_byte(8'h35, 200);
    check("t1_valid", int'(cmd_valid), 1);
    check("t1_frame", int'({cmd_lmotor, cmd_rmotor, cmd_dur}), 24'h95B635);
    check("t1_count", int'(count), 1);
    drain();

    // Partial frame times out, following frame is kept.
    e0 = err_seen;
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    repeat (TIMEOUT + 5) step();
    send_frame(8'h33, 8'h44, 8'h55);
    step();
    check("t2_err_pulses", err_seen - e0, 1);
    check("t2_count", int'(count), 1);
    check("t2_frame", int'({cmd_lmotor, cmd_rmotor, cmd_dur}), 24'h334455);
    drain();

    // DEPTH+1 frames with no consumer: last one dropped with a single overflow pulse.
    o0 = ovf_seen;
    for (int k = 0; k <= DEPTH; k++) send_frame(8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2));
    step();
    step();
    check("t3_count", int'(count), DEPTH);
    check("t3_ovf_pulses", ovf_seen - o0, 1);
    check("t3_head", int'({cmd_lmotor, cmd_rmotor, cmd_dur}), 24'h000102);
    drain();

    // Full queue, third byte lands on a pop: no overflow and count stays full.
    for (int k = 0; k < DEPTH; k++) send_frame(8'h40 + 8'(k), 8'h50, 8'h60);
    o0 = ovf_seen;
    send_byte(8'hE1, 1);
    send_byte(8'hE2, 1);
    step();
    cmd_ready = 1'b1;
    rx_valid  = 1'b1;
    rx_byte   = 8'hE3;
    step();
    cmd_ready = 1'b0;
    rx_valid  = 1'b0;
    step();
    check("t4_count", int'(count), DEPTH);
    check("t4_ovf_pulses", ovf_seen - o0, 0);
    drain();

    // Reset in the middle of a frame discards it silently.
    e0 = err_seen;
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_frame(8'hA0, 8'hB0, 8'hC0);
    step();
    check("t5_count", int'(count), 1);
    check("t5_frame", int'({cmd_lmotor, cmd_rmotor, cmd_dur}), 24'hA0B0C0);
    repeat (TIMEOUT + 2) step();
    check("t5_err_pulses", err_seen - e0, 0);
    drain();

    // Push/pop one at a time across pointer wrap, including zero/0x80 bytes.
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      if (k == 3) send_frame(8'h80, 8'h00, 8'h00);
      else send_frame(8'($urandom), 8'($urandom), 8'($urandom));
      step();
      check("t6_count_one", int'(count), 1);
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
    end
    step();
    check("t6_count_zero", int'(count), 0);

    // Random byte stream, random gaps around the timeout and random consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       g = TIMEOUT + $urandom_range(0, 40);
        1:       g = TIMEOUT - 4 + $urandom_range(0, 8);
        default: g = $urandom_range(0, 3);
      endcase
      send_byte(8'($urandom), g);
    end
    rand_ready = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
